// File: rtl/core_phase_seq_pkg.sv
// Shared definitions for the core phase sequencer: FSM state encodings,
// default sizing and symbolic stage indices used by the stage blocks.
package core_phase_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_t;

  localparam int DEF_NSTAGE = 5;
  localparam int DEF_TMO_W  = 4;
  localparam int DEF_CNT_W  = 32;

  // Stage indices so stage blocks can pick their bit of phase[]/stall[]
  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_EXEC   = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;

endpackage

// File: rtl/core_phase_seq_retire_cnt.sv
// Retired-instruction counter. Wraps modulo 2**CNT_W; a clear request
// takes priority over an increment in the same cycle.
module core_phase_seq_retire_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count completions, clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/core_phase_seq.sv
// Core phase sequencer: steps a one-hot phase through NSTAGE stages with
// per-stage stall hold, a sticky stall watchdog, a debug halt handshake
// honoured only at instruction boundaries, and a retired-instruction count.
module core_phase_seq
  import core_phase_seq_pkg::*;
#(
  parameter int NSTAGE = DEF_NSTAGE,
  parameter int TMO_W  = DEF_TMO_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              halt_req,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] phase,
  output logic [NSTAGE-1:0] stall,
  output logic              retire,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              halted,
  output logic              stall_tmo
);

  localparam logic [NSTAGE-1:0] FIRST_PHASE = {{(NSTAGE-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  WD_MAX      = '1;
  localparam logic [TMO_W-1:0]  WD_PRE_MAX  = WD_MAX - 1'b1;

  seq_state_t       state;
  logic [TMO_W-1:0] wdog;
  logic             stalled;
  logic             advance;
  logic             complete;

  // Only the active stage's stall request matters; phase is zero outside RUN
  assign stall    = phase & stall_req;
  assign stalled  = |stall;
  assign advance  = (state == ST_RUN) & ~stalled;
  assign complete = advance & phase[NSTAGE-1];
  assign retire   = complete;

  // Main sequencer: start, phase rotation, halt only at completion, resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      phase  <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            if (halt_req) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else begin
              state <= ST_RUN;
              phase <= FIRST_PHASE;
            end
          end
        end
        ST_RUN: begin
          if (advance) begin
            if (phase[NSTAGE-1]) begin
              if (halt_req) begin
                state  <= ST_HALTED;
                phase  <= '0;
                halted <= 1'b1;
              end else begin
                phase <= FIRST_PHASE;
              end
            end else begin
              phase <= {phase[NSTAGE-2:0], 1'b0};
            end
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state  <= ST_RUN;
            phase  <= FIRST_PHASE;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          phase  <= '0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog: count consecutive stalled RUN cycles, saturate and latch timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog      <= '0;
      stall_tmo <= 1'b0;
    end else if ((state == ST_RUN) && stalled) begin
      if (wdog != WD_MAX) begin
        wdog <= wdog + 1'b1;
      end
      if (wdog == WD_PRE_MAX) begin
        stall_tmo <= 1'b1;
      end
    end else begin
      wdog <= '0;
    end
  end

  core_phase_seq_retire_cnt #(
    .CNT_W(CNT_W)
  ) u_retire_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (complete),
    .clr  (cnt_clr),
    .cnt  (retire_cnt)
  );

  // Phase must be one-hot while running and all-zero in IDLE/HALTED
  always @(posedge clk) begin
    if (rst_n) begin
      assert ((state == ST_RUN) ? $onehot(phase) : (phase == '0));
    end
  end

endmodule

// File: tb/tb_core_phase_seq.sv
// Directed bench for core_phase_seq with a small behavioural model feeding a
// scoreboard queue, plus spot checks of the key scenarios.
module tb_core_phase_seq;

  localparam int NS = 5;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic [NS-1:0] stall_req;
  logic          halt_req;
  logic          cnt_clr;
  logic [NS-1:0] phase;
  logic [NS-1:0] stall;
  logic          retire;
  logic [3:0]    retire_cnt;
  logic          halted;
  logic          stall_tmo;

  typedef struct {
    logic [NS-1:0] phase;
    logic [NS-1:0] stall;
    logic          retire;
    logic [3:0]    cnt;
    logic          halted;
    logic          tmo;
  } exp_t;

  exp_t sb[$];

  int m_state;
  int m_stg;
  int m_wd;
  int m_cnt;
  bit m_tmo;
  int nvec = 0;
  int nfail = 0;

  core_phase_seq #(
    .NSTAGE(NS),
    .TMO_W (4),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .stall_req (stall_req),
    .halt_req  (halt_req),
    .cnt_clr   (cnt_clr),
    .phase     (phase),
    .stall     (stall),
    .retire    (retire),
    .retire_cnt(retire_cnt),
    .halted    (halted),
    .stall_tmo (stall_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_stg   = 0;
    m_wd    = 0;
    m_cnt   = 0;
    m_tmo   = 1'b0;
    sb.delete();
  endtask

  // Drive inputs, push this cycle's expected outputs, then step the model
  task automatic applyStimulus(input logic r, input logic [NS-1:0] sreq,
                               input logic h, input logic c);
    exp_t e;
    bit   st;
    bit   ret;
    run       = r;
    stall_req = sreq;
    halt_req  = h;
    cnt_clr   = c;
    st  = (m_state == 1) && sreq[m_stg];
    ret = (m_state == 1) && !st && (m_stg == NS - 1);
    e.phase  = (m_state == 1) ? NS'(1 << m_stg) : '0;
    e.stall  = e.phase & sreq;
    e.retire = ret;
    e.cnt    = 4'(m_cnt);
    e.halted = (m_state == 2);
    e.tmo    = m_tmo;
    sb.push_back(e);
    if (c) m_cnt = 0;
    else if (ret) m_cnt = (m_cnt + 1) % 16;
    if (st) begin
      if (m_wd < 15) m_wd++;
      if (m_wd == 15) m_tmo = 1'b1;
    end else begin
      m_wd = 0;
    end
    case (m_state)
      0: if (r) begin
        if (h) m_state = 2;
        else begin m_state = 1; m_stg = 0; end
      end
      1: if (!st) begin
        if (m_stg == NS - 1) begin
          if (h) m_state = 2;
          m_stg = 0;
        end else begin
          m_stg++;
        end
      end
      2: if (!h) begin m_state = 1; m_stg = 0; end
      default: m_state = 0;
    endcase
  endtask

  // Pop the oldest expectation and compare against the settled outputs
  task automatic checkOutput(input string tag);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      nvec++;
      nfail++;
      $error("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_phase"}, 32'(phase), 32'(e.phase));
      chk({tag, "_stall"}, 32'(stall), 32'(e.stall));
      chk({tag, "_retire"}, 32'(retire), 32'(e.retire));
      chk({tag, "_cnt"}, 32'(retire_cnt), 32'(e.cnt));
      chk({tag, "_halted"}, 32'(halted), 32'(e.halted));
      chk({tag, "_tmo"}, 32'(stall_tmo), 32'(e.tmo));
    end
  endtask

  task automatic cycle(input logic r, input logic [NS-1:0] sreq, input logic h,
                       input logic c, input string tag);
    applyStimulus(r, sreq, h, c);
    checkOutput(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int guard;
    run       = 1'b0;
    stall_req = '0;
    halt_req  = 1'b0;
    cnt_clr   = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_tmo", 32'(stall_tmo), 32'd0);
    chk("rst_cnt", 32'(retire_cnt), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    rst_n = 1'b1;
    modelReset();

    // Idle holds without run, then start and free-run 20 cycles
    cycle(1'b0, '0, 1'b0, 1'b0, "idle");
    cycle(1'b1, '0, 1'b0, 1'b0, "start");
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, "t1");
    chk("t1_cnt4", 32'(retire_cnt), 32'd4);
    chk("t1_phase1", 32'(phase), 32'd1);

    // Stall stage 2 for three cycles
    cycle(1'b0, '0, 1'b0, 1'b0, "t2");
    cycle(1'b0, '0, 1'b0, 1'b0, "t2");
    chk("t2_at4", 32'(phase), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 5'b00100, 1'b0, 1'b0, "t2_stall");
      chk("t2_hold4", 32'(phase), 32'd4);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, "t2_rel");
    chk("t2_to8", 32'(phase), 32'd8);
    cycle(1'b0, '0, 1'b0, 1'b0, "t2");
    cycle(1'b0, '0, 1'b0, 1'b0, "t2");
    chk("t2_cnt5", 32'(retire_cnt), 32'd5);

    // Halt raised mid-instruction, honoured only at completion
    cycle(1'b0, '0, 1'b0, 1'b0, "t3");
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, "t3_halt");
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_phase0", 32'(phase), 32'd0);
    chk("t3_cnt6", 32'(retire_cnt), 32'd6);
    cycle(1'b0, '0, 1'b1, 1'b0, "t3_hold");
    cycle(1'b0, '0, 1'b0, 1'b0, "t3_resume");
    chk("t3_resume_phase", 32'(phase), 32'd1);
    chk("t3_resume_halted", 32'(halted), 32'd0);

    // Watchdog on stage 1 stall held 20 cycles
    cycle(1'b0, '0, 1'b0, 1'b0, "t4");
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 5'b00010, 1'b0, 1'b0, "t4_stall");
      if (i == 14) chk("t4_tmo_before", 32'(stall_tmo), 32'd0);
      if (i == 15) chk("t4_tmo_set", 32'(stall_tmo), 32'd1);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, "t4_rel");
    chk("t4_phase4", 32'(phase), 32'd4);
    chk("t4_tmo_sticky", 32'(stall_tmo), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, "t4");

    // Stall on last stage with halt pending: hold, then halt at completion
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, "hd");
    for (int i = 0; i < 2; i++) cycle(1'b0, 5'b10000, 1'b1, 1'b0, "hd_stall");
    chk("hd_phase16", 32'(phase), 32'd16);
    chk("hd_not_halted", 32'(halted), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, "hd_done");
    chk("hd_halted", 32'(halted), 32'd1);
    chk("hd_cnt8", 32'(retire_cnt), 32'd8);
    cycle(1'b0, '0, 1'b0, 1'b0, "hd_resume");

    // Short halt pulse is lost
    cycle(1'b0, '0, 1'b1, 1'b0, "pl");
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, "pl");
    chk("pl_halted", 32'(halted), 32'd0);
    chk("pl_phase1", 32'(phase), 32'd1);

    // Counter wrap and clear-over-increment
    guard = 0;
    while (m_cnt != 15 && guard < 500) begin
      cycle(1'b0, '0, 1'b0, 1'b0, "t5_fill");
      guard++;
    end
    chk("t5_cnt15", 32'(retire_cnt), 32'd15);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, "t5_wrap");
    chk("t5_wrap0", 32'(retire_cnt), 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, "t5_one");
    chk("t5_cnt1", 32'(retire_cnt), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, "t5");
    cycle(1'b0, '0, 1'b0, 1'b1, "t5_clr");
    chk("t5_clr0", 32'(retire_cnt), 32'd0);
    chk("t5_clr_phase1", 32'(phase), 32'd1);

    // Asynchronous reset mid-instruction
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, "t6");
    cycle(1'b0, '0, 1'b0, 1'b0, "t6");
    chk("t6_cnt1", 32'(retire_cnt), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, "t6");
    chk("t6_phase8", 32'(phase), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_phase", 32'(phase), 32'd0);
    chk("t6_async_cnt", 32'(retire_cnt), 32'd0);
    chk("t6_async_tmo", 32'(stall_tmo), 32'd0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Run with halt pending from IDLE goes straight to HALTED
    cycle(1'b1, '0, 1'b1, 1'b0, "idle_halt");
    chk("idle_halt_halted", 32'(halted), 32'd1);
    cycle(1'b1, '0, 1'b0, 1'b0, "idle_resume");
    chk("idle_resume_phase", 32'(phase), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b1, '0, 1'b0, 1'b0, "tail");
    chk("tail_cnt1", 32'(retire_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
